counter_timer_ctrl: RTL

Programmable one-shot/periodic timer controller that sequences a single settable up-counter. Accepts start/stop commands with a period and prescale, paces the counter, and raises a level interrupt with an acknowledge handshake on each expiration. Sits between the host-facing configuration registers and the shared counter datapath.

---
 rtl/counter_timer_pkg.sv | 11 +
 rtl/counter_timer_ctrl_counter.sv | 34 +++
 rtl/counter_timer_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/counter_timer_pkg.sv
// rtl/counter_timer_pkg.sv - shared types and defaults for the counter timer controller
package counter_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MISSED_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/counter_timer_ctrl_counter.sv
// rtl/counter_timer_ctrl_counter.sv - settable up-counter shared by timer datapaths
module counter #(
    parameter int WIDTH            = 32,
    parameter int INCREMENT_AMOUNT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [WIDTH-1:0] set_value_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // set has priority; a clear set advances by the fixed increment
    always_comb begin
        count_d = count_q + WIDTH'(INCREMENT_AMOUNT);
        if (set_i) begin
            count_d = set_value_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_timer_ctrl.sv
// rtl/counter_timer_ctrl.sv - one-shot/periodic timer sequencing a settable counter
module counter_timer_ctrl
    import counter_timer_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int MISSED_WIDTH   = MISSED_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      periodic_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      irq_ack_i,
    output logic                      busy_o,
    output logic [WIDTH-1:0]          count_o,
    output logic                      irq_o,
    output logic [MISSED_WIDTH-1:0]   missed_o,
    output logic                      err_o
);

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0]          period_q, period_d;
    logic                      periodic_q, periodic_d;
    logic                      irq_q, irq_d;
    logic [MISSED_WIDTH-1:0]   missed_q, missed_d;
    logic                      err_q, err_d;

    logic                      cnt_set;
    logic [WIDTH-1:0]          cnt_set_value;
    logic [WIDTH-1:0]          count;
    logic                      tick;
    logic                      expire;
    logic                      start_legal;

    counter #(
        .WIDTH            (WIDTH),
        .INCREMENT_AMOUNT (1)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .set_i       (cnt_set),
        .set_value_i (cnt_set_value),
        .count_o     (count)
    );

    assign start_legal = (period_i != '0);
    assign tick        = (prescaler_q == prescale_q);

    always_comb begin
        state_d       = state_q;
        prescaler_d   = prescaler_q;
        prescale_d    = prescale_q;
        period_d      = period_q;
        periodic_d    = periodic_q;
        err_d         = 1'b0;
        expire        = 1'b0;
        cnt_set       = 1'b1;
        cnt_set_value = count;

        // stop outranks start, so a start alongside stop is dropped silently
        if (stop_i) begin
            state_d     = IDLE;
            prescaler_d = '0;
        end else if (start_i && start_legal) begin
            state_d       = RUN;
            prescaler_d   = '0;
            prescale_d    = prescale_i;
            period_d      = period_i;
            periodic_d    = periodic_i;
            cnt_set_value = '0;
        end else begin
            err_d = start_i;
            if (state_q == RUN) begin
                prescaler_d = tick ? '0 : prescaler_q + PRESCALE_WIDTH'(1);
                if (tick) begin
                    if (count == period_q - WIDTH'(1)) begin
                        expire        = 1'b1;
                        cnt_set_value = '0;
                        if (!periodic_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_set = 1'b0;
                    end
                end
            end
        end
    end

    // an expiration landing on an ack keeps irq high but still clears missed
    always_comb begin
        irq_d    = irq_q;
        missed_d = missed_q;
        if (irq_ack_i) begin
            irq_d    = 1'b0;
            missed_d = '0;
        end
        if (expire) begin
            irq_d = 1'b1;
            if (irq_q && !irq_ack_i && (missed_q != '1)) begin
                missed_d = missed_q + MISSED_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            prescale_q  <= '0;
            period_q    <= '0;
            periodic_q  <= 1'b0;
            irq_q       <= 1'b0;
            missed_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            prescale_q  <= prescale_d;
            period_q    <= period_d;
            periodic_q  <= periodic_d;
            irq_q       <= irq_d;
            missed_q    <= missed_d;
            err_q       <= err_d;
        end
    end

    assign busy_o   = (state_q == RUN);
    assign count_o  = count;
    assign irq_o    = irq_q;
    assign missed_o = missed_q;
    assign err_o    = err_q;

endmodule
